// File: rtl/tone_sequencer.sv
// Note-list player: queues {half-period, duration} entries and drives a square-wave
// tone generator, holding each note for its duration followed by a fixed silent gap.
module tone_sequencer #(
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 50000,
    parameter int GAP_MS   = 10
) (
    input  logic                     clk50,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [31:0]              wr_fr,
    input  logic [15:0]              wr_dur,
    input  logic                     stop,
    output logic [31:0]              tone_fr,
    output logic                     tone_en,
    output logic                     busy,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     done,
    output logic                     overflow,
    output logic [1:0]               state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [15:0]   GAP_UNITS = 16'(GAP_MS);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t          state;
    logic [47:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            pop;
    logic            wr_accept;
    logic            wr_reject;
    logic [CW-1:0]   count_nxt;
    logic [31:0]     head_fr;
    logic [15:0]     head_dur;
    logic [TW-1:0]   tick;
    logic [15:0]     units;

    // Handshake: the FIFO has no ready output; a write is taken when wr_en is high,
    // stop is low and there is room, counting the slot freed by a same-cycle LOAD pop.
    assign pop       = (state == LOAD);
    assign wr_accept = wr_en && !stop && ((count != DEPTH_C) || pop);
    assign wr_reject = wr_en && !stop && !wr_accept;
    assign {head_fr, head_dur} = mem[rd_ptr];
    assign state_dbg = state;

    always_comb begin
        count_nxt = count;
        if (stop) begin
            count_nxt = '0;
        end else if (wr_accept && !pop) begin
            count_nxt = count + 1'b1;
        end else if (!wr_accept && pop) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk50) begin
        if (!rst && wr_accept) begin
            mem[wr_ptr] <= {wr_fr, wr_dur};
        end
    end

    always_ff @(posedge clk50) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_C);
            if (stop) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                if (wr_accept) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (wr_reject) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Outputs are set on the transition into each state so they line up with it.
    always_ff @(posedge clk50) begin
        if (rst || stop) begin
            state   <= IDLE;
            tone_fr <= '0;
            tone_en <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            tick    <= '0;
            units   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= (count_nxt != '0);
                    end
                end
                LOAD: begin
                    if (head_dur == 16'd0) begin
                        if (count > CW'(1)) begin
                            state <= LOAD;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            done  <= 1'b1;
                            busy  <= (count_nxt != '0);
                        end
                    end else begin
                        state   <= PLAY;
                        tone_fr <= head_fr;
                        tone_en <= (head_fr != 32'd0);
                        tick    <= '0;
                        units   <= head_dur;
                        busy    <= 1'b1;
                    end
                end
                PLAY: begin
                    busy <= 1'b1;
                    if (tick == TICK_LAST) begin
                        tick <= '0;
                        if (units == 16'd1) begin
                            state   <= GAP;
                            tone_en <= 1'b0;
                            units   <= GAP_UNITS;
                        end else begin
                            units <= units - 1'b1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                GAP: begin
                    if (tick == TICK_LAST) begin
                        tick <= '0;
                        if (units == 16'd1) begin
                            if (count != '0) begin
                                state <= LOAD;
                                busy  <= 1'b1;
                            end else begin
                                state <= IDLE;
                                done  <= 1'b1;
                                busy  <= (count_nxt != '0);
                            end
                        end else begin
                            units <= units - 1'b1;
                            busy  <= 1'b1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                        busy <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= (count_nxt != '0);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: directed note scenarios plus random traffic, all checked
// cycle by cycle against a queue-based note-list model.
module tb_tone_sequencer;

    localparam int DEPTH    = 4;
    localparam int TICK_DIV = 10;
    localparam int GAP_MS   = 2;
    localparam int CW       = 3;
    localparam int EW       = 32 + 1 + 1 + 1 + CW + 1 + 1;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_PLAY = 2;
    localparam int PH_GAP  = 3;

    logic          clk50 = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [31:0]   wr_fr = '0;
    logic [15:0]   wr_dur = '0;
    logic          stop = 1'b0;
    logic [31:0]   tone_fr;
    logic          tone_en;
    logic          busy;
    logic          full;
    logic [CW-1:0] count;
    logic          done;
    logic          overflow;
    logic [1:0]    state_dbg;

    tone_sequencer #(
        .DEPTH(DEPTH),
        .TICK_DIV(TICK_DIV),
        .GAP_MS(GAP_MS)
    ) dut (
        .clk50(clk50),
        .rst(rst),
        .wr_en(wr_en),
        .wr_fr(wr_fr),
        .wr_dur(wr_dur),
        .stop(stop),
        .tone_fr(tone_fr),
        .tone_en(tone_en),
        .busy(busy),
        .full(full),
        .count(count),
        .done(done),
        .overflow(overflow),
        .state_dbg(state_dbg)
    );

    // clock / reset block
    always #5 clk50 = ~clk50;

    int cyc = 0;
    always @(posedge clk50) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // scoreboard: one expected output vector per cycle
    logic [EW-1:0] exp_q[$];

    // reference model: queue of pending notes plus the remaining cycles of the current phase
    logic [47:0] mq[$];
    int          ph = PH_IDLE;
    int          left = 0;
    logic [31:0] mfr = '0;
    logic        mdone = 1'b0;
    logic        movf = 1'b0;

    task automatic model_step(input logic w, input logic [31:0] f, input logic [15:0] d,
                              input logic s, input logic r);
        int            size;
        bit            popping;
        logic [47:0]   e;
        logic [CW-1:0] cnt;
        if (r || s) begin
            mq.delete();
            ph    = PH_IDLE;
            left  = 0;
            mfr   = '0;
            mdone = 1'b0;
            movf  = 1'b0;
        end else begin
            size    = mq.size();
            popping = (ph == PH_LOAD);
            mdone   = 1'b0;
            case (ph)
                PH_IDLE: if (size != 0) ph = PH_LOAD;
                PH_LOAD: begin
                    e = mq.pop_front();
                    if (e[15:0] == 16'd0) begin
                        if (size > 1) ph = PH_LOAD;
                        else begin ph = PH_IDLE; mdone = 1'b1; end
                    end else begin
                        mfr  = e[47:16];
                        ph   = PH_PLAY;
                        left = int'(e[15:0]) * TICK_DIV;
                    end
                end
                PH_PLAY: begin
                    left--;
                    if (left == 0) begin ph = PH_GAP; left = GAP_MS * TICK_DIV; end
                end
                default: begin
                    left--;
                    if (left == 0) begin
                        if (size != 0) ph = PH_LOAD;
                        else begin ph = PH_IDLE; mdone = 1'b1; end
                    end
                end
            endcase
            if (w) begin
                if (size < DEPTH || popping) mq.push_back({f, d});
                else movf = 1'b1;
            end
        end
        cnt = CW'(mq.size());
        exp_q.push_back({mfr, (ph == PH_PLAY && mfr != 32'd0), (ph != PH_IDLE || mq.size() != 0),
                         (mq.size() == DEPTH), cnt, mdone, movf});
    endtask

    // driver tasks
    task automatic step(input logic w, input logic [31:0] f, input logic [15:0] d,
                        input logic s, input logic r);
        wr_en  = w;
        wr_fr  = f;
        wr_dur = d;
        stop   = s;
        rst    = r;
        model_step(w, f, d, s, r);
        @(posedge clk50);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 32'd0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic write(input logic [31:0] f, input logic [15:0] d);
        step(1'b1, f, d, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // monitor: compares every cycle and logs tone edges / done pulses
    int            rise_cyc[$];
    logic [31:0]   rise_fr[$];
    int            fall_cyc[$];
    int            done_cyc[$];
    logic          prev_en = 1'b0;
    logic [EW-1:0] mon_got;
    logic [EW-1:0] mon_exp;

    always @(negedge clk50) begin
        mon_got = {tone_fr, tone_en, busy, full, count, done, overflow};
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            n_checks++;
            if (mon_got !== mon_exp) begin
                n_errors++;
                $display("FAIL outputs cyc=%0d got fr=%0d en=%b busy=%b full=%b cnt=%0d done=%b ovf=%b expected fr=%0d en=%b busy=%b full=%b cnt=%0d done=%b ovf=%b",
                         cyc, mon_got[EW-1:EW-32], mon_got[7], mon_got[6], mon_got[5], mon_got[4:2],
                         mon_got[1], mon_got[0], mon_exp[EW-1:EW-32], mon_exp[7], mon_exp[6],
                         mon_exp[5], mon_exp[4:2], mon_exp[1], mon_exp[0]);
            end
        end
        if (tone_en === 1'b1 && prev_en !== 1'b1) begin
            rise_cyc.push_back(cyc);
            rise_fr.push_back(tone_fr);
        end
        if (tone_en !== 1'b1 && prev_en === 1'b1) fall_cyc.push_back(cyc);
        if (done === 1'b1) done_cyc.push_back(cyc);
        prev_en = tone_en;
    end

    task automatic clear_logs();
        rise_cyc.delete();
        rise_fr.delete();
        fall_cyc.delete();
        done_cyc.delete();
    endtask

    int          w0;
    int          w1;
    int          r;
    logic [31:0] played [6];

    initial begin
        step(1'b0, 32'd0, 16'd0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 16'd0, 1'b0, 1'b1);
        idle(2);

        // single note
        clear_logs();
        w0 = cyc;
        write(32'd100, 16'd3);
        idle(60);
        check("single_rises", rise_cyc.size(), 1);
        check("single_rise_at", rise_cyc[0] - w0, 3);
        check("single_fr", rise_fr[0], 100);
        check("single_fall_at", fall_cyc[0] - w0, 33);
        check("single_dones", done_cyc.size(), 1);
        check("single_done_at", done_cyc[0] - w0, 53);

        // rest note, discarded entry, then a short note
        clear_logs();
        w0 = cyc;
        write(32'd0, 16'd2);
        write(32'd7, 16'd0);
        write(32'd9, 16'd1);
        idle(90);
        check("rest_rises", rise_cyc.size(), 1);
        check("rest_rise_at", rise_cyc[0] - w0, 45);
        check("rest_fr", rise_fr[0], 9);
        check("rest_dones", done_cyc.size(), 1);
        check("rest_done_at", done_cyc[0] - w0, 75);

        // overflow while playing, then a write that coincides with a full LOAD pop
        clear_logs();
        w0 = cyc;
        write(32'd5, 16'd2);
        idle(4);
        for (int i = 0; i < 5; i++) write(32'(201 + i), 16'd1);
        idle(33);
        write(32'd206, 16'd1);
        check("ovf_count_after_pop", count, 4);
        check("ovf_full_after_pop", full, 1);
        check("ovf_sticky", overflow, 1);
        idle(200);
        played = '{32'd5, 32'd201, 32'd202, 32'd203, 32'd204, 32'd206};
        check("ovf_rises", rise_cyc.size(), 6);
        for (int i = 0; i < 6; i++) check("ovf_played_fr", rise_fr[i], played[i]);
        check("ovf_still_set", overflow, 1);

        // stop mid-note with two queued entries
        clear_logs();
        w0 = cyc;
        write(32'd11, 16'd3);
        write(32'd12, 16'd1);
        write(32'd13, 16'd1);
        idle(10);
        step(1'b0, 32'd0, 16'd0, 1'b1, 1'b0);
        check("stop_en", tone_en, 0);
        check("stop_fr", tone_fr, 0);
        check("stop_count", count, 0);
        check("stop_busy", busy, 0);
        check("stop_ovf", overflow, 0);
        idle(80);
        check("stop_dones", done_cyc.size(), 0);
        check("stop_rises", rise_cyc.size(), 1);

        // reset during the gap, then a fresh note
        clear_logs();
        w0 = cyc;
        write(32'd21, 16'd1);
        idle(19);
        step(1'b0, 32'd0, 16'd0, 1'b0, 1'b1);
        check("rst_fr", tone_fr, 0);
        check("rst_en", tone_en, 0);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_done", done, 0);
        idle(1);
        w1 = cyc;
        write(32'd22, 16'd2);
        idle(60);
        check("rst_rises", rise_cyc.size(), 2);
        check("rst_rise_at", rise_cyc[1] - w1, 3);
        check("rst_fr_after", rise_fr[1], 22);
        check("rst_dones", done_cyc.size(), 1);
        check("rst_done_at", done_cyc[0] - w1, 43);

        // back-to-back notes
        clear_logs();
        w0 = cyc;
        write(32'd31, 16'd1);
        write(32'd32, 16'd1);
        idle(80);
        check("b2b_rises", rise_cyc.size(), 2);
        check("b2b_spacing", rise_cyc[1] - rise_cyc[0], 31);
        check("b2b_dones", done_cyc.size(), 1);
        check("b2b_done_at", done_cyc[0] - w0, 64);

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 199);
            if (r < 1) step(1'b0, 32'd0, 16'd0, 1'b0, 1'b1);
            else if (r < 4) step(1'b0, 32'd0, 16'd0, 1'b1, 1'b0);
            else if (r < 24)
                write(($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000)),
                      16'($urandom_range(0, 2)));
            else idle(1);
        end
        idle(150);
        @(negedge clk50);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Note-list player that drives the square-wave tone generator's half-period (`fr`) and `enable` inputs.
- The j1 CPU (via UART/IO write) pushes {half-period, duration} entries into an internal FIFO.
- The sequencer pops entries and holds each tone for its duration in milliseconds, then inserts a fixed silent gap.
- Status is reported back for polling.

Parameters:
- DEPTH, 8, FIFO entries (power of two, ≥2).
- TICK_DIV, 50000, clk50 cycles per duration unit (1 ms at 50 MHz).
- GAP_MS, 10, silent gap between notes, in duration units (≥1).

Ports:
- clk50  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  push {wr_fr, wr_dur} into FIFO this cycle.
- wr_fr  in  32  half-period count for the generator; 0 = rest (silence).
- wr_dur  in  16  note duration in units; 0 = discard entry.
- stop  in  1  abort: flush FIFO, silence output.
- tone_fr  out  32  to generator fr.
- tone_en  out  1  to generator enable.
- busy  out  1  high when state ≠ IDLE or FIFO non-empty.
- full  out  1  FIFO count == DEPTH.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- done  out  1  one-cycle pulse when the list finishes normally.
- overflow  out  1  sticky: a write was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1 at an edge) takes priority over everything:
  - FIFO emptied; state IDLE.
  - tone_fr=0, tone_en=0, done=0, overflow=0, count=0, full=0, busy=0.
- All outputs are registered; tone_en=1 exactly in cycles where state==PLAY and the current fr≠0.
- FIFO:
  - Write accepted if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
  - A rejected write sets overflow; overflow clears only on rst or stop.
  - Simultaneous accepted write and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD, PLAY, GAP.
  - IDLE: if count≠0, go to LOAD next cycle.
  - LOAD: pop head entry.
    - If dur==0: entry is discarded. Go to LOAD again if the FIFO is still non-empty after the pop, else IDLE with a done pulse. No PLAY, no GAP.
    - Else: latch tone_fr=fr, load duration counter, go to PLAY.
  - PLAY: lasts exactly dur*TICK_DIV cycles, then go to GAP.
  - GAP: tone_en=0, tone_fr held. Lasts exactly GAP_MS*TICK_DIV cycles. Then go to LOAD if count≠0, else IDLE and assert done for 1 cycle.
- Timing:
  - Tick prescaler and unit counter restart on entry to PLAY and to GAP. The tick counter is a free-running 0..TICK_DIV-1 wrap counter only while in PLAY/GAP.
  - Latency: wr_en in cycle N into an empty idle block puts LOAD in N+2 and tone_en high from N+3.
  - Back-to-back notes have no extra cycles: GAP→LOAD→PLAY adds exactly 1 LOAD cycle.
- Writes during PLAY/GAP are queued normally and do not disturb the current note.
- stop (lower priority than rst, higher than everything else):
  - Next cycle: FIFO flushed, state IDLE, tone_en=0, tone_fr=0, overflow=0, done=0.
  - A write in the same cycle as stop is dropped and does not set overflow.
- rst or stop mid-PLAY truncates the note immediately; there is no gap and no done pulse.
- Arithmetic:
  - Duration/gap unit counters are 16 bits; GAP_MS must fit in 16 bits.
  - The tick counter is sized $clog2(TICK_DIV).

Test Plan (TICK_DIV=10, GAP_MS=2, DEPTH=4):
- Single note: write fr=100, dur=3 at cycle 0.
  - tone_en=1, tone_fr=100 on cycles 3–32 (30 cycles); tone_en=0 on cycles 33–52.
  - done pulses at cycle 53; busy low from 53.
- Rest and discard: write {fr=0,dur=2}, {fr=7,dur=0}, {fr=9,dur=1}.
  - tone_en stays 0 for the rest note's 20-cycle PLAY.
  - The dur=0 entry adds one LOAD cycle.
  - fr=9 then plays for 10 cycles; exactly one done pulse.
- Overflow: write 5 entries back-to-back with the FSM in PLAY.
  - count saturates at 4, full=1, overflow=1.
  - The 5th entry is never played.
  - A write coinciding with a LOAD pop when full is accepted (count stays 4).
- Stop mid-note: during PLAY of note 1 with 2 queued entries, pulse stop.
  - Next cycle: tone_en=0, tone_fr=0, count=0, state IDLE.
  - No done pulse; overflow cleared.
- Reset mid-operation: assert rst during GAP.
  - All outputs are at reset values on the next cycle.
  - A write one cycle after rst deasserts plays with the standard 3-cycle latency.
- Back-to-back: two notes dur=1 each.
  - Second tone_en rising edge occurs exactly 10+20+1 cycles after the first.
